// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, issues imem requests steered by the
// predictor, and buffers responses in an in-order queue until decode takes them.
module fetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] pcF_o,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_addr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stallD_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_pred_o
);

    localparam int unsigned PtrW = $clog2(FQ_DEPTH);
    localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);

    logic [XLEN-1:0]     pcQ, pcD;
    logic [PtrW-1:0]     rdPtrQ, rdPtrD, wrPtrQ, wrPtrD, fillPtrQ, fillPtrD;
    logic [CntW-1:0]     countQ, countD, dropCntQ, dropCntD;
    logic [FQ_DEPTH-1:0] hasDataQ, hasDataD;
    logic [XLEN-1:0]     entryPcQ   [FQ_DEPTH];
    logic                entryPredQ [FQ_DEPTH];
    logic [31:0]         entryDataQ [FQ_DEPTH];

    logic            push, pop, discard, fill, headValid;
    logic [CntW:0]   credit, dropRedir;
    logic [CntW-1:0] numData, pending;
    logic            unusedAddrBits;

    assign unusedAddrBits = ^{pred_addr_i[1:0], redirect_pc_i[1:0]};

    assign credit = {1'b0, countQ} + {1'b0, dropCntQ};

    // Gated by rstn_i so the request drops the moment reset asserts.
    assign imem_req_o  = rstn_i & ~redirect_i & (credit < (CntW+1)'(FQ_DEPTH));
    assign imem_addr_o = pcQ;
    assign pcF_o       = pcQ;

    assign push      = imem_req_o & imem_gnt_i;
    assign discard   = imem_rvalid_i & (dropCntQ != '0);
    assign fill      = imem_rvalid_i & (dropCntQ == '0);
    assign headValid = hasDataQ[rdPtrQ] & (countQ != '0) & ~redirect_i;
    assign pop       = headValid & ~stallD_i;

    assign instr_valid_o = headValid;
    assign instr_o       = entryDataQ[rdPtrQ];
    assign instr_pc_o    = entryPcQ[rdPtrQ];
    assign instr_pred_o  = entryPredQ[rdPtrQ];

    // Popped entries clear has_data, so queued-but-empty entries = count - popcount.
    always_comb begin
        numData = '0;
        for (int i = 0; i < FQ_DEPTH; i++) begin
            numData = numData + CntW'(hasDataQ[i]);
        end
        pending   = countQ - numData;
        dropRedir = {1'b0, dropCntQ} + {1'b0, pending} + (CntW+1)'(push)
                    - (CntW+1)'(discard) - (CntW+1)'(fill);
    end

    always_comb begin
        pcD      = pcQ;
        rdPtrD   = rdPtrQ;
        wrPtrD   = wrPtrQ;
        fillPtrD = fillPtrQ;
        countD   = countQ;
        dropCntD = dropCntQ;
        hasDataD = hasDataQ;
        if (redirect_i) begin
            pcD      = {redirect_pc_i[XLEN-1:2], 2'b00};
            rdPtrD   = '0;
            wrPtrD   = '0;
            fillPtrD = '0;
            countD   = '0;
            hasDataD = '0;
            dropCntD = dropRedir[CntW-1:0];
        end else begin
            if (push) begin
                pcD    = pred_taken_i ? {pred_addr_i[XLEN-1:2], 2'b00} : pcQ + XLEN'(4);
                wrPtrD = wrPtrQ + PtrW'(1);
            end
            if (discard) begin
                dropCntD = dropCntQ - CntW'(1);
            end
            if (fill) begin
                hasDataD[fillPtrQ] = 1'b1;
                fillPtrD           = fillPtrQ + PtrW'(1);
            end
            if (pop) begin
                hasDataD[rdPtrQ] = 1'b0;
                rdPtrD           = rdPtrQ + PtrW'(1);
            end
            countD = countQ + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pcQ      <= RESET_PC;
            rdPtrQ   <= '0;
            wrPtrQ   <= '0;
            fillPtrQ <= '0;
            countQ   <= '0;
            dropCntQ <= '0;
            hasDataQ <= '0;
        end else begin
            pcQ      <= pcD;
            rdPtrQ   <= rdPtrD;
            wrPtrQ   <= wrPtrD;
            fillPtrQ <= fillPtrD;
            countQ   <= countD;
            dropCntQ <= dropCntD;
            hasDataQ <= hasDataD;
        end
    end

    // Payload needs no reset; has_data qualifies every entry.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entryPcQ[wrPtrQ]   <= pcQ;
            entryPredQ[wrPtrQ] <= pred_taken_i;
        end
        if (fill) begin
            entryDataQ[fillPtrQ] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: in-order fixed-latency memory model, pop/grant logs,
// and hand-computed expectations for sequencing, prediction, backpressure and redirects.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imemReq, imemGnt, imemRvalid;
    logic [31:0] imemAddr, imemRdata;
    logic [31:0] pcF, predAddr, redirectPc, instr, instrPc;
    logic        predTaken, redirect, stallD, instrValid, instrPred;

    logic        predEn = 1'b0;
    logic [31:0] predPc = '0;
    int          memLat = 1;
    int          cyc = 0;
    int          nChecks = 0;
    int          nFails = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] data;
    } popRec_t;

    popRec_t     popLog[$];
    logic [31:0] grantLog[$];
    logic [31:0] memAddr[$];
    int          memDue[$];

    assign predTaken = predEn && (pcF == predPc);

    fetch_ctrl dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .imem_req_o    (imemReq),
        .imem_addr_o   (imemAddr),
        .imem_gnt_i    (imemGnt),
        .imem_rvalid_i (imemRvalid),
        .imem_rdata_i  (imemRdata),
        .pcF_o         (pcF),
        .pred_taken_i  (predTaken),
        .pred_addr_i   (predAddr),
        .redirect_i    (redirect),
        .redirect_pc_i (redirectPc),
        .stallD_i      (stallD),
        .instr_valid_o (instrValid),
        .instr_o       (instr),
        .instr_pc_o    (instrPc),
        .instr_pred_o  (instrPred)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Memory: samples req/gnt and pops just before each edge, answers memLat cycles later.
    initial begin
        imemRvalid = 1'b0;
        imemRdata  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rstn) begin
                memAddr.delete();
                memDue.delete();
            end else begin
                if (imemReq && imemGnt) begin
                    memAddr.push_back(imemAddr);
                    memDue.push_back(cyc + memLat);
                    grantLog.push_back(imemAddr);
                end
                if (instrValid && !stallD) begin
                    popLog.push_back('{pc: instrPc, pred: instrPred, data: instr});
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            if (rstn && memDue.size() > 0 && memDue[0] <= cyc) begin
                imemRvalid = 1'b1;
                imemRdata  = memData(memAddr[0]);
                void'(memAddr.pop_front());
                void'(memDue.pop_front());
            end else begin
                imemRvalid = 1'b0;
                imemRdata  = '0;
            end
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #3;
    endtask

    // Leaves time in cycle 1 after release, 3 units past the edge.
    task automatic applyReset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        popLog.delete();
        grantLog.delete();
        rstn = 1'b1;
        #1;
    endtask

    task automatic waitPops(input int n);
        for (int i = 0; i < 40 && popLog.size() < n; i++) cycle();
        checkValue("popCountBounded", 32'(popLog.size()), 32'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [31:0] expPc[5];
        logic [31:0] expPred[5];
        imemGnt    = 1'b1;
        redirect   = 1'b0;
        redirectPc = '0;
        stallD     = 1'b0;
        predAddr   = '0;

        // Reset state
        #3;
        checkValue("rstReq", 32'(imemReq), 32'd0);
        checkValue("rstValid", 32'(instrValid), 32'd0);
        checkValue("rstPcF", pcF, 32'h0);

        // Sequential fetch with a predicted-taken branch at 0x8
        predEn   = 1'b1;
        predPc   = 32'h8;
        predAddr = 32'h100;
        memLat   = 1;
        applyReset();
        checkValue("firstReq", 32'(imemReq), 32'd1);
        checkValue("firstAddr", imemAddr, 32'h0);
        cycle();
        checkValue("cyc2Valid", 32'(instrValid), 32'd0);
        expPc   = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
        expPred = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkValue("seqValid", 32'(instrValid), 32'd1);
            checkValue("seqPc", instrPc, expPc[i]);
            checkValue("seqPred", 32'(instrPred), expPred[i]);
            checkValue("seqData", instr, memData(expPc[i]));
        end
        checkValue("grantAfterBranch", grantLog[3], 32'h100);

        // Backpressure: four grants fill the queue, one pop reopens one slot
        predEn = 1'b0;
        stallD = 1'b1;
        applyReset();
        repeat (4) cycle();
        checkValue("fullReq", 32'(imemReq), 32'd0);
        checkValue("fullGrants", 32'(grantLog.size()), 32'd4);
        cycle();
        checkValue("fullHeadValid", 32'(instrValid), 32'd1);
        checkValue("fullHeadPc", instrPc, 32'h0);
        stallD = 1'b0;
        cycle();
        stallD = 1'b1;
        #1;
        checkValue("reopenReq", 32'(imemReq), 32'd1);
        checkValue("reopenPops", 32'(popLog.size()), 32'd1);
        checkValue("reopenPopPc", popLog[0].pc, 32'h0);
        cycle();
        checkValue("refullReq", 32'(imemReq), 32'd0);
        checkValue("refullGrants", 32'(grantLog.size()), 32'd5);
        checkValue("refullLastAddr", grantLog[grantLog.size()-1], 32'h10);
        stallD = 1'b0;

        // Redirect with three fetches outstanding, latency 3
        memLat = 3;
        applyReset();
        repeat (3) cycle();
        redirectPc = 32'h200;
        redirect   = 1'b1;
        #1;
        checkValue("redirReq", 32'(imemReq), 32'd0);
        checkValue("redirValid", 32'(instrValid), 32'd0);
        cycle();
        redirect = 1'b0;
        #1;
        checkValue("postRedirReq", 32'(imemReq), 32'd1);
        checkValue("postRedirAddr", imemAddr, 32'h200);
        checkValue("noStalePops", 32'(popLog.size()), 32'd0);
        waitPops(1);
        checkValue("redirFirstPc", popLog[0].pc, 32'h200);
        checkValue("redirFirstData", popLog[0].data, memData(32'h200));

        // Redirect colliding with a fill and a would-be pop, latency 2
        memLat = 2;
        applyReset();
        repeat (5) cycle();
        #1;
        checkValue("collHeadValid", 32'(instrValid), 32'd1);
        checkValue("collHeadPc", instrPc, 32'h8);
        redirectPc = 32'h300;
        redirect   = 1'b1;
        #1;
        checkValue("collValidMasked", 32'(instrValid), 32'd0);
        cycle();
        redirect = 1'b0;
        #1;
        checkValue("collPopsBefore", 32'(popLog.size()), 32'd2);
        checkValue("collReq", 32'(imemReq), 32'd1);
        checkValue("collAddr", imemAddr, 32'h300);
        popLog.delete();
        waitPops(1);
        checkValue("collFirstPc", popLog[0].pc, 32'h300);
        checkValue("collFirstData", popLog[0].data, memData(32'h300));

        // Asynchronous reset mid-burst
        memLat = 1;
        applyReset();
        repeat (3) cycle();
        checkValue("burstValid", 32'(instrValid), 32'd1);
        rstn = 1'b0;
        #1;
        checkValue("asyncReq", 32'(imemReq), 32'd0);
        checkValue("asyncValid", 32'(instrValid), 32'd0);
        checkValue("asyncPcF", pcF, 32'h0);
        applyReset();
        waitPops(1);
        checkValue("resumePc", popLog[0].pc, 32'h0);
        checkValue("resumeData", popLog[0].data, memData(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
